// File: rtl/iter_counter_pkg.sv
// ============================================================================
// Module  : iter_counter_pkg
// Brief   : Shared FSM encoding and default width for the iteration counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package iter_counter_pkg;

   localparam int DEFAULT_N = 4;

   // 2'b11 is unused; the FSM decodes it as IDLE-safe and returns to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COUNT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

`default_nettype wire

// File: rtl/iter_counter_if.sv
// ============================================================================
// Module  : iter_counter_if
// Brief   : Start/enable/load handshake and count status of the iteration counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface iter_counter_if
   import iter_counter_pkg::*;
#(
   parameter int N = DEFAULT_N
) ();

   logic         start;
   logic         en;
   logic [N-1:0] init;
   logic [N-1:0] cnt;
   logic         co;
   logic         busy;
   logic         done;

   modport master (
      output start, en, init,
      input  cnt, co, busy, done
   );

   modport slave (
      input  start, en, init,
      output cnt, co, busy, done
   );

endinterface

`default_nettype wire

// File: rtl/And.sv
// ============================================================================
// Module  : And
// Brief   : N-input AND reduction, used as the all-ones terminal-count detector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module And #(
   parameter int N = 2
) (
   input  logic [N-1:0] a,
   output logic         y
);

   assign y = &a;

endmodule

`default_nettype wire

// File: rtl/inc_n.sv
// ============================================================================
// Module  : inc_n
// Brief   : N-bit +1 incrementer, ripple chain of half-adder cells, modulo 2^N.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inc_n #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   output logic [N-1:0] s
);

   // Carry out of the top bit is deliberately not formed: wrap is modulo 2^N.
   logic [N-1:0] c;

   assign c[0] = 1'b1;

   generate
      for (genvar i = 0; i < N; i++) begin : g_bit
         assign s[i] = a[i] ^ c[i];
         if (i < N - 1) begin : g_carry
            assign c[i+1] = a[i] & c[i];
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/iter_counter.sv
// ============================================================================
// Module  : iter_counter
// Brief   : Loadable N-bit iteration counter with start/done handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iter_counter
   import iter_counter_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst,
   iter_counter_if.slave bus
);

   state_t       state_q, state_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic [N-1:0] cnt_inc;
   logic         co;

   inc_n #(.N(N)) u_inc (
      .a (cnt_q),
      .s (cnt_inc)
   );

   And #(.N(N)) u_and (
      .a (cnt_q),
      .y (co)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               cnt_d   = bus.init;
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (bus.en) begin
               if (co) begin
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.cnt  = cnt_q;
   assign bus.co   = co;
   assign bus.busy = (state_q == ST_COUNT);
   assign bus.done = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_iter_counter.sv
// ============================================================================
// Module  : tb_iter_counter
// Brief   : Directed vector table plus hand sequences for iter_counter, N=4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iter_counter;

   localparam int N    = 4;
   localparam int NVEC = 15;

   typedef struct {
      logic         start;
      logic         en;
      logic [N-1:0] init;
      logic [N-1:0] cnt;
      logic         co;
      logic         busy;
      logic         done;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vecs [NVEC];

   iter_counter_if #(.N(N)) bus ();

   iter_counter #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [N-1:0] e_cnt,
                        input logic e_co, input logic e_busy, input logic e_done);
      logic [N+2:0] got, exp;
      got = {bus.cnt, bus.co, bus.busy, bus.done};
      exp = {e_cnt, e_co, e_busy, e_done};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got cnt=%0d co=%b busy=%b done=%b, expected cnt=%0d co=%b busy=%b done=%b",
                  name, bus.cnt, bus.co, bus.busy, bus.done, e_cnt, e_co, e_busy, e_done);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, outputs are checked there too.
   task automatic step(input logic s, input logic e, input logic [N-1:0] i);
      bus.start = s;
      bus.en    = e;
      bus.init  = i;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      checks = 0;
      errors = 0;
      bus.start = 1'b0;
      bus.en    = 1'b0;
      bus.init  = '0;

      //              start en   init   cnt   co    busy  done
      vecs[0]  = '{1'b1, 1'b0, 4'd12, 4'd12, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 4'd0,  4'd13, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 4'd0,  4'd14, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 4'd0,  4'd15, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 4'd5,  4'd0,  1'b0, 1'b0, 1'b0}; // start in DONE ignored
      vecs[6]  = '{1'b1, 1'b1, 4'd14, 4'd14, 1'b0, 1'b1, 1'b0}; // start wins over en
      vecs[7]  = '{1'b0, 1'b1, 4'd0,  4'd15, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 4'd0,  4'd15, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 4'd3,  4'd15, 1'b1, 1'b1, 1'b0}; // start in COUNT ignored
      vecs[10] = '{1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0};

      // Asynchronous reset, observed before any clock edge.
      rst = 1'b1;
      #1 rst = 1'b0;
      #1 check("reset_no_clock", 4'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].start, vecs[i].en, vecs[i].init);
         check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].co, vecs[i].busy, vecs[i].done);
      end

      // Reset mid-count with cnt=6, then en alone must not move the counter.
      step(1'b1, 1'b0, 4'd6);
      check("load6", 4'd6, 1'b0, 1'b1, 1'b0);
      #2 rst = 1'b0;
      #1 check("reset_mid_count", 4'd0, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 4'd0);
         check($sformatf("en_after_reset%0d", i), 4'd0, 1'b0, 1'b0, 1'b0);
      end

      // Reset while in DONE kills the pulse.
      step(1'b1, 1'b0, 4'd15);
      step(1'b0, 1'b1, 4'd0);
      check("done_before_reset", 4'd0, 1'b0, 1'b0, 1'b1);
      #2 rst = 1'b0;
      #1 check("reset_in_done", 4'd0, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b1;

      // Back-to-back: loop from 15, then start at the first legal edge after done.
      step(1'b1, 1'b0, 4'd15);
      step(1'b0, 1'b1, 4'd0);
      check("b2b_first_done", 4'd0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b0, 4'd13);
      check("b2b_start", 4'd13, 1'b0, 1'b1, 1'b0);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 20) begin
         step(1'b0, 1'b1, 4'd0);
         lat++;
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL b2b_latency: got %0d cycles, expected 4", lat);
      end
      check("b2b_done", 4'd0, 1'b0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/iter_counter.md
# iter_counter

Loadable N-bit iteration counter with a start/done handshake. It is the register stage that drives the N-input `And` terminal-count detector: `And` consumes the counter bits and returns all-ones (`co`). The controller uses that result to end an iteration loop. The counter bits are built from the team's sequential cells, the increment from C1/C2 logic cells, and `co` comes from an instance of `And #(N)`.

## Interface
- `N`, default 4: counter width. Must be at least 2, which `And` requires.

- `clk` input 1: single clock, rising-edge.
- `rst` input 1: reset, asynchronous and active-low.
- `start` input 1: load `init` and begin counting. Sampled only in IDLE.
- `en` input 1: count enable. Sampled only in COUNT.
- `init` input N: start value, loaded on an accepted `start`.
- `cnt` output N: current count, registered.
- `co` output 1: terminal count, combinational. Equals `cnt` all-ones, produced by `And`.
- `busy` output 1: high while in COUNT.
- `done` output 1: one-cycle pulse after the loop terminates.

## Operation
- FSM states:
  - IDLE: `cnt` holds its value.
    - `start`=1: `cnt`←`init`, go to COUNT.
    - Otherwise stay in IDLE.
  - COUNT:
    - `en`=1 and `co`=0: `cnt`←`cnt`+1.
    - `en`=1 and `co`=1: `cnt`←0 (natural wrap), go to DONE.
    - `en`=0: hold.
    - `start` is ignored in this state.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally. `start` is ignored here. `cnt` holds 0.
- Arithmetic: increment is modulo 2^N with no carry out beyond `co`. `cnt`+1 from all-ones is 0.
- `co` is valid in every state, because it is a pure function of `cnt`.
- `init` all-ones: `co`=1 on the first COUNT cycle, so the first `en` terminates the loop.
- `start` and `en` high together in IDLE: `start` wins and `en` is ignored.
- `busy` and `done` are never high together.
- `busy`=(state==COUNT) and `done`=(state==DONE). Both are decoded from registered state, so they are glitch-free.

## Timing
- Reset values, with `rst` low and no clock required:
  - state IDLE
  - `cnt`=0, `co`=0
  - `busy`=0, `done`=0
- `start` accepted at edge k: `cnt`=`init` and `busy`=1 after edge k.
- Each `en` in COUNT updates `cnt` after that edge.
- `co` follows `cnt` combinationally in the same cycle.
- Terminating `en` at edge k: after k, `busy`=0, `done`=1, `cnt`=0. After k+1, `done`=0 and state is IDLE.
- A new `start` is accepted at edge k+2 at the earliest.
- Loop latency from the `start` edge to `done`: (2^N − `init`) enabled cycles plus one cycle.
- Reset mid-loop, in any state: immediate return to reset values. No `done` pulse is produced.
- No combinational path from `start`, `en` or `init` to any output. `co` depends only on `cnt`.

## Structure
- Shared package or header:
  - state encoding constants IDLE=2'b00, COUNT=2'b01, DONE=2'b10 (2'b11 decodes as IDLE-safe and returns to IDLE)
  - default width constant
- Sub-modules:
  - `And #(N)` for `co`: the existing module, reused and not duplicated.
  - One natural new sub-module, `inc_n`: an N-bit incrementer with a ripple chain of C1/C2 cells.
- Top level holds:
  - N-bit state register
  - 2-bit FSM register
  - next-state and mux logic: load / increment / clear / hold

## Test plan
- Reset: assert `rst`=0 mid-count with `cnt`=4'b0110 → outputs go to 0 and IDLE at once. Release, then `en`=1 for 5 cycles → `cnt` stays 0 and `busy`=0.
- Basic loop, N=4: `init`=4'd12, `start` pulse, `en` held high → `cnt` goes 12, 13, 14, 15 with `co`=1 at 15. Next edge gives `cnt`=0 and `done`=1 for one cycle. `busy` is high for 4 cycles.
- Gapped enable: `init`=4'd14 with `en`=1,0,0,1 → `cnt` goes 14, 15, 15, 15, then 0 with `done`. `co` stays 1 through the stall.
- `init`=4'hF: `start`, then one `en` → `done` is asserted after the first enabled edge.
- Ignored commands:
  - `start` pulsed during COUNT → `cnt` is not reloaded.
  - `start` during DONE → not accepted; state is IDLE the next cycle.
  - `start`+`en` together in IDLE → `cnt`=`init`, not `init`+1.
- Back-to-back: `start` at the first legal cycle after `done` → a second loop from `init`=4'd13 completes with `done` exactly 4 cycles later.
